i2c_codec_target: RTL and testbench

I2C write-only target that models the WM8731 codec's control port. It is the responder to the codec I2C initializer. It decodes the 3-byte register-write frames (device address, {reg[6:0], data[8]}, data[7:0]) and drives ACKs on the open-drain SDA line. It keeps a 16 x 9-bit shadow register file for board-level self-check and simulation of the audio front end.

---
 rtl/i2c_codec_target.sv | 176 +++++++++++++++++
 tb/tb_i2c_codec_target.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_target.sv
// i2c_codec_target: write-only I2C target modelling the WM8731 control port.
// Decodes 3-byte register writes, ACKs on open-drain SDA and keeps a 16 x 9 shadow file.
module i2c_codec_target #(
    parameter logic [6:0]  DEV_ADDR    = 7'h1A,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_reg_wr,
    output logic [6:0] o_reg_addr,
    output logic [8:0] o_reg_data,
    output logic       o_err,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data
);
    localparam int unsigned LP_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ACK_A, ST_BYTE1, ST_ACK_1, ST_BYTE2, ST_ACK_2, ST_IGNORE
    } state_t;

    logic [LP_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                 r_scl_d, r_sda_d;
    logic                 w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    state_t               r_state, w_next;
    logic [2:0]           r_bitcnt;
    logic [6:0]           r_shift;
    logic [7:0]           w_byte;
    logic                 w_byte_done, w_in_ack, w_next_ack, w_partial, w_commit, w_err_evt;
    logic                 r_ack_on, r_ign_bit, r_ign_err;
    logic [6:0]           r_pend_addr;
    logic                 r_pend_d8;
    logic [7:0]           r_pend_lo;
    logic                 r_reg_wr, r_err;
    logic [6:0]           r_reg_addr;
    logic [8:0]           r_reg_data, r_rd_data;
    logic [8:0]           r_shadow [16];

    // Bus idles high, so the synchronizers reset to 1 to avoid a spurious edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[LP_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[LP_STAGES-2:0], i_sda};
            r_scl_d    <= r_scl_sync[LP_STAGES-1];
            r_sda_d    <= r_sda_sync[LP_STAGES-1];
        end
    end

    assign w_scl       = r_scl_sync[LP_STAGES-1];
    assign w_sda       = r_sda_sync[LP_STAGES-1];
    assign w_scl_rise  = w_scl & ~r_scl_d;
    assign w_scl_fall  = ~w_scl & r_scl_d;
    // SCL must be high in both samples, so an SCL rise always wins as a data bit.
    assign w_start     = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop      = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte      = {r_shift, w_sda};
    assign w_byte_done = w_scl_rise && (r_bitcnt == 3'd7);
    assign w_in_ack    = (r_state == ST_ACK_A) || (r_state == ST_ACK_1) || (r_state == ST_ACK_2);
    assign w_next_ack  = (w_next == ST_ACK_A) || (w_next == ST_ACK_1) || (w_next == ST_ACK_2);
    assign w_partial   = (r_state == ST_BYTE1) || (r_state == ST_ACK_1) ||
                         (r_state == ST_BYTE2) || (r_state == ST_ACK_2);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_commit  = 1'b0;
        w_err_evt = 1'b0;
        if (w_start) begin
            w_next    = ST_ADDR;
            w_err_evt = w_partial;
        end else if (w_stop) begin
            w_next    = ST_IDLE;
            w_err_evt = w_partial;
        end else begin
            case (r_state)
                ST_ADDR: if (w_byte_done) begin
                    if (w_byte[7:1] == DEV_ADDR && !w_byte[0]) begin
                        w_next = ST_ACK_A;
                    end else begin
                        w_next    = ST_IGNORE;
                        w_err_evt = 1'b1;
                    end
                end
                ST_ACK_A:  if (w_scl_fall && r_ack_on) w_next = ST_BYTE1;
                ST_BYTE1:  if (w_byte_done) w_next = ST_ACK_1;
                ST_ACK_1:  if (w_scl_fall && r_ack_on) w_next = ST_BYTE2;
                ST_BYTE2:  if (w_byte_done) w_next = ST_ACK_2;
                ST_ACK_2:  if (w_scl_fall && r_ack_on) begin
                    w_next   = ST_IGNORE;
                    w_commit = 1'b1;
                end
                ST_IGNORE: w_err_evt = w_scl_fall && r_ign_bit && !r_ign_err;
                default:   w_next = r_state;
            endcase
        end
    end

    always_comb begin
        o_sda_oe = 1'b0;
        if (w_in_ack && r_ack_on) o_sda_oe = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_ack_on    <= 1'b0;
            r_ign_bit   <= 1'b0;
            r_ign_err   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_d8   <= 1'b0;
            r_pend_lo   <= '0;
            r_reg_wr    <= 1'b0;
            r_err       <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_data  <= '0;
        end else begin
            if (w_scl_rise) r_shift <= w_byte[6:0];
            if (w_start || w_in_ack)  r_bitcnt <= '0;
            else if (w_scl_rise)      r_bitcnt <= r_bitcnt + 3'd1;
            if (!w_next_ack)          r_ack_on <= 1'b0;
            else if (w_scl_fall)      r_ack_on <= 1'b1;
            // An address reject has already reported its error; a post-commit extra byte has not.
            if (r_state != ST_IGNORE) begin
                r_ign_bit <= 1'b0;
                r_ign_err <= (r_state == ST_ADDR);
            end else begin
                if (w_scl_rise) r_ign_bit <= 1'b1;
                if (w_err_evt)  r_ign_err <= 1'b1;
            end
            if (r_state == ST_BYTE1 && w_byte_done) {r_pend_addr, r_pend_d8} <= w_byte;
            if (r_state == ST_BYTE2 && w_byte_done) r_pend_lo <= w_byte;
            r_reg_wr <= w_commit;
            r_err    <= w_err_evt;
            if (w_commit) begin
                r_reg_addr <= r_pend_addr;
                r_reg_data <= {r_pend_d8, r_pend_lo};
            end
        end
    end

    // Register 0x0F is the codec reset register: it wipes the whole shadow file.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < 16; i++) r_shadow[i] <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_commit && r_pend_addr[6:4] == 3'd0) begin
                if (r_pend_addr[3:0] == 4'hF) begin
                    for (int unsigned i = 0; i < 16; i++) r_shadow[i] <= '0;
                end else begin
                    r_shadow[r_pend_addr[3:0]] <= {r_pend_d8, r_pend_lo};
                end
            end
            r_rd_data <= r_shadow[i_rd_addr];
        end
    end

    assign o_reg_wr   = r_reg_wr;
    assign o_err      = r_err;
    assign o_reg_addr = r_reg_addr;
    assign o_reg_data = r_reg_data;
    assign o_rd_data  = r_rd_data;
endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed bench for i2c_codec_target: an open-drain I2C master model drives frames,
// expected commits go to a scoreboard queue and are checked as o_reg_wr pulses appear.
module tb_i2c_codec_target;
    logic       clk = 1'b0;
    logic       rst, m_scl, m_sda, sda_line;
    logic       sda_oe, reg_wr, err;
    logic [6:0] reg_addr;
    logic [8:0] reg_data, rd_data;
    logic [3:0] rd_addr;

    typedef struct { logic [6:0] a; logic [8:0] d; } wr_t;
    wr_t exp_q[$];
    wr_t mon_w;

    int n_cmp = 0, n_mis = 0, wr_cnt = 0, err_cnt = 0;
    int e0, w0;
    logic       acked;
    logic [7:0] byte_v;

    always #5 clk = ~clk;
    assign sda_line = m_sda & ~sda_oe;

    i2c_codec_target #(.DEV_ADDR(7'h1A), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_scl(m_scl), .i_sda(sda_line),
        .o_sda_oe(sda_oe), .o_reg_wr(reg_wr), .o_reg_addr(reg_addr), .o_reg_data(reg_data),
        .o_err(err), .i_rd_addr(rd_addr), .o_rd_data(rd_data)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic qwait();
        repeat (8) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b0; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b1; qwait();
        qwait();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    qwait();
        m_scl = 1'b1; qwait(); qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic send_chk(input string tag, input logic [7:0] b, input logic exp_ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        acked = (sda_line === 1'b0);
        qwait();
        m_scl = 1'b0; qwait();
        chk(tag, 16'(acked), 16'(exp_ack));
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] idx, input logic [8:0] exp);
        rd_addr = idx;
        repeat (2) @(negedge clk);
        chk(tag, 16'(rd_data), 16'(exp));
    endtask

    // Scoreboard consumer: every commit pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && reg_wr) begin
            wr_cnt++;
            chk("wr_expected", 16'(exp_q.size() != 0), 16'h1);
            if (exp_q.size() != 0) begin
                mon_w = exp_q.pop_front();
                chk("wr_addr", 16'(reg_addr), 16'(mon_w.a));
                chk("wr_data", 16'(reg_data), 16'(mon_w.d));
            end
        end
        if (!rst && err) err_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; rd_addr = 4'd0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_oe",       16'(sda_oe),   16'h0);
        chk("rst_reg_wr",   16'(reg_wr),   16'h0);
        chk("rst_err",      16'(err),      16'h0);
        chk("rst_reg_addr", 16'(reg_addr), 16'h0);
        chk("rst_reg_data", 16'(reg_data), 16'h0);
        chk("rst_rd_data",  16'(rd_data),  16'h0);

        // Basic write: reg 4 = 0x015
        e0 = err_cnt; w0 = wr_cnt;
        exp_q.push_back('{7'h04, 9'h015});
        i2c_start();
        send_chk("f1_ack_dev", 8'h34, 1'b1);
        send_chk("f1_ack_b1",  8'h08, 1'b1);
        send_chk("f1_ack_b2",  8'h15, 1'b1);
        i2c_stop();
        chk("f1_wr_cnt",   16'(wr_cnt - w0), 16'h1);
        chk("f1_err_cnt",  16'(err_cnt - e0), 16'h0);
        chk("f1_reg_addr", 16'(reg_addr), 16'h04);
        chk("f1_reg_data", 16'(reg_data), 16'h015);
        rd_chk("f1_rd4", 4'd4, 9'h015);

        // Wrong device address: no ACKs, single error, nothing committed
        e0 = err_cnt; w0 = wr_cnt;
        i2c_start();
        send_chk("f2_nack_dev", 8'h36, 1'b0);
        chk("f2_err_addr", 16'(err_cnt - e0), 16'h1);
        send_chk("f2_nack_b1", 8'h08, 1'b0);
        send_chk("f2_nack_b2", 8'h15, 1'b0);
        i2c_stop();
        chk("f2_err_cnt", 16'(err_cnt - e0), 16'h1);
        chk("f2_wr_cnt",  16'(wr_cnt - w0), 16'h0);
        rd_chk("f2_rd4", 4'd4, 9'h015);

        // Reg 7 = 0x042, then codec reset register clears the shadow file
        e0 = err_cnt;
        exp_q.push_back('{7'h07, 9'h042});
        i2c_start();
        send_chk("f3_ack_dev", 8'h34, 1'b1);
        send_chk("f3_ack_b1",  8'h0E, 1'b1);
        send_chk("f3_ack_b2",  8'h42, 1'b1);
        i2c_stop();
        rd_chk("f3_rd7", 4'd7, 9'h042);
        exp_q.push_back('{7'h0F, 9'h000});
        i2c_start();
        send_chk("f4_ack_dev", 8'h34, 1'b1);
        send_chk("f4_ack_b1",  8'h1E, 1'b1);
        send_chk("f4_ack_b2",  8'h00, 1'b1);
        i2c_stop();
        chk("f4_reg_addr", 16'(reg_addr), 16'h0F);
        chk("f4_err_cnt",  16'(err_cnt - e0), 16'h0);
        rd_chk("f4_rd4", 4'd4, 9'h000);
        rd_chk("f4_rd7", 4'd7, 9'h000);

        // Partial frame cut by repeated START, then a full frame
        e0 = err_cnt; w0 = wr_cnt;
        i2c_start();
        send_chk("f5_ack_dev", 8'h34, 1'b1);
        send_chk("f5_ack_b1",  8'h09, 1'b1);
        exp_q.push_back('{7'h06, 9'h09F});
        i2c_start();
        chk("f5_err_rstart", 16'(err_cnt - e0), 16'h1);
        send_chk("f5_ack_dev2", 8'h34, 1'b1);
        send_chk("f5_ack_b1b",  8'h0C, 1'b1);
        send_chk("f5_ack_b2",   8'h9F, 1'b1);
        i2c_stop();
        chk("f5_err_cnt", 16'(err_cnt - e0), 16'h1);
        chk("f5_wr_cnt",  16'(wr_cnt - w0), 16'h1);
        rd_chk("f5_rd6", 4'd6, 9'h09F);

        // Extra fourth byte is not ACKed and flags an error
        e0 = err_cnt; w0 = wr_cnt;
        exp_q.push_back('{7'h04, 9'h015});
        i2c_start();
        send_chk("f6_ack_dev", 8'h34, 1'b1);
        send_chk("f6_ack_b1",  8'h08, 1'b1);
        send_chk("f6_ack_b2",  8'h15, 1'b1);
        send_chk("f6_nack_b3", 8'hAA, 1'b0);
        i2c_stop();
        chk("f6_err_cnt",  16'(err_cnt - e0), 16'h1);
        chk("f6_wr_cnt",   16'(wr_cnt - w0), 16'h1);
        chk("f6_reg_data", 16'(reg_data), 16'h015);
        rd_chk("f6_rd4", 4'd4, 9'h015);

        // Asynchronous reset while the ACK_1 acknowledge is driven
        i2c_start();
        send_chk("f7_ack_dev", 8'h34, 1'b1);
        byte_v = 8'h08;
        for (int i = 7; i >= 0; i--) write_bit(byte_v[i]);
        chk("f7_oe_before_rst", 16'(sda_oe), 16'h1);
        #3 rst = 1'b1;
        #1 chk("f7_oe_async_rel", 16'(sda_oe), 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("f7_reg_addr_rst", 16'(reg_addr), 16'h0);
        i2c_stop();
        e0 = err_cnt; w0 = wr_cnt;
        exp_q.push_back('{7'h05, 9'h055});
        i2c_start();
        send_chk("f8_ack_dev", 8'h34, 1'b1);
        send_chk("f8_ack_b1",  8'h0A, 1'b1);
        send_chk("f8_ack_b2",  8'h55, 1'b1);
        i2c_stop();
        chk("f8_wr_cnt",  16'(wr_cnt - w0), 16'h1);
        chk("f8_err_cnt", 16'(err_cnt - e0), 16'h0);
        rd_chk("f8_rd5", 4'd5, 9'h055);
        rd_chk("f8_rd4", 4'd4, 9'h000);

        chk("sb_drained", 16'(exp_q.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
